// File: rtl/mem_stage_pkg.sv
// Shared pipeline types for the memory-access stage.
// EX/MEM and MEM/WB bundles, funct3 codes, FSM states.
package mem_stage_pkg;

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      WAIT_RSP = 1'b1
   } mem_state_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [1:0] RESULT_LOAD = 2'b01;

   typedef struct packed {
      logic       RegWrite;
      logic [1:0] ResultSrc;
      logic       MemWrite;
   } exmem_ctrl_t;

   typedef struct packed {
      logic [31:0] ALUResult;
      logic [31:0] WriteData;
      logic [31:0] PCPlus4;
      logic [31:0] ImmExt;
      logic [4:0]  Rd;
      logic [2:0]  funct3;
   } exmem_data_t;

   typedef struct packed {
      logic       RegWrite;
      logic [1:0] ResultSrc;
   } memwb_ctrl_t;

   typedef struct packed {
      logic [31:0] ALUResult;
      logic [31:0] load_data;
      logic [31:0] PCPlus4;
      logic [31:0] ImmExt;
      logic [4:0]  Rd;
   } memwb_data_t;

   // funct3[1:0]: 00 byte, 01 half, anything else is a word access.
   function automatic logic isMisaligned(
      input logic [2:0] f3,
      input logic [1:0] lo
   );
      unique case (f3[1:0])
         2'b00:   return 1'b0;
         2'b01:   return lo[0];
         default: return lo != 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Pipeline-register bundles between EX/MEM and MEM/WB.
// Writers use .wr, readers use .rd.
interface exmem_if;
   mem_stage_pkg::exmem_ctrl_t ctrl;
   mem_stage_pkg::exmem_data_t data;
   modport wr (output ctrl, output data);
   modport rd (input ctrl, input data);
endinterface

interface memwb_if;
   mem_stage_pkg::memwb_ctrl_t ctrl;
   mem_stage_pkg::memwb_data_t data;
   modport wr (output ctrl, output data);
   modport rd (input ctrl, input data);
endinterface

// File: rtl/load_align.sv
// Picks the addressed lane of a load word and extends it.
// Unknown funct3 codes return the raw word.
module load_align
   import mem_stage_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic [2:0]  funct3,
   output logic [31:0] load_data
);

   logic [7:0]  laneB;
   logic [15:0] laneH;

   assign laneB = rdata[{addr, 3'b000} +: 8];
   assign laneH = addr[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      load_data = rdata;
      unique case (funct3)
         F3_LB:   load_data = {{24{laneB[7]}}, laneB};
         F3_LH:   load_data = {{16{laneH[15]}}, laneH};
         F3_LBU:  load_data = {24'h0, laneB};
         F3_LHU:  load_data = {16'h0, laneH};
         default: load_data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: data-memory handshake, load formatting,
// MEM/WB register, and front-end stall while memory is busy.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   exmem_if.rd             inputs,
   memwb_if.wr             outputs,
   output logic            dmem_req_valid,
   input  logic            dmem_req_ready,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [3:0]      dmem_be,
   input  logic            dmem_rsp_valid,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            mem_stall,
   output logic            misalign
);

   mem_state_t  state;
   mem_state_t  stateNext;
   memwb_ctrl_t wbCtrl;
   memwb_data_t wbData;

   logic [31:0] addr;
   logic [2:0]  f3;
   logic        idle;
   logic        isLoad;
   logic        isStore;
   logic        misAl;
   logic        reqValid;
   logic        storeReq;
   logic [3:0]  laneBe;
   logic [31:0] laneData;
   logic [31:0] fmtData;

   assign addr    = inputs.data.ALUResult;
   assign f3      = inputs.data.funct3;
   assign idle    = state == IDLE;
   assign isLoad  = inputs.ctrl.RegWrite &&
                    inputs.ctrl.ResultSrc == RESULT_LOAD;
   assign isStore = inputs.ctrl.MemWrite && !isLoad;
   assign misAl   = (isLoad || isStore) &&
                    isMisaligned(f3, addr[1:0]);

   // Gated by rst_n so the port is quiet while memory is in reset.
   assign reqValid = rst_n && idle && (isLoad || isStore) && !misAl;
   assign storeReq = reqValid && isStore;

   always_comb begin
      laneBe   = 4'hF;
      laneData = inputs.data.WriteData;
      unique case (f3[1:0])
         2'b00: begin
            laneBe   = 4'b0001 << addr[1:0];
            laneData = {4{inputs.data.WriteData[7:0]}};
         end
         2'b01: begin
            laneBe   = 4'b0011 << {addr[1], 1'b0};
            laneData = {2{inputs.data.WriteData[15:0]}};
         end
         default: begin
            laneBe   = 4'hF;
            laneData = inputs.data.WriteData;
         end
      endcase
   end

   assign dmem_req_valid = reqValid;
   assign dmem_we        = storeReq;
   assign dmem_addr      = reqValid ? {addr[31:2], 2'b00} : '0;
   assign dmem_be        = storeReq ? laneBe : 4'h0;
   assign dmem_wdata     = storeReq ? laneData : '0;

   always_comb begin
      mem_stall = 1'b0;
      if (rst_n) begin
         if (!idle)
            mem_stall = !dmem_rsp_valid;
         else if (isLoad && !misAl)
            mem_stall = 1'b1;
         else if (isStore && !misAl)
            mem_stall = !dmem_req_ready;
      end
   end

   always_comb begin
      stateNext = state;
      if (idle && reqValid && isLoad && dmem_req_ready)
         stateNext = WAIT_RSP;
      else if (!idle && dmem_rsp_valid)
         stateNext = IDLE;
   end

   load_align uAlign (
      .rdata     (dmem_rdata),
      .addr      (addr[1:0]),
      .funct3    (f3),
      .load_data (fmtData)
   );

   always_comb begin
      logic take;
      wbCtrl = '0;
      wbData = '0;
      take   = 1'b0;
      if (!idle) begin
         take = dmem_rsp_valid;
      end else if (!misAl) begin
         unique case (1'b1)
            isLoad:  take = 1'b0;
            isStore: take = dmem_req_ready;
            default: take = 1'b1;
         endcase
      end
      if (take) begin
         wbCtrl.RegWrite   = inputs.ctrl.RegWrite && !isStore;
         wbCtrl.ResultSrc  = inputs.ctrl.ResultSrc;
         wbData.ALUResult  = inputs.data.ALUResult;
         wbData.load_data  = idle ? 32'h0 : fmtData;
         wbData.PCPlus4    = inputs.data.PCPlus4;
         wbData.ImmExt     = inputs.data.ImmExt;
         wbData.Rd         = inputs.data.Rd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         misalign     <= 1'b0;
         outputs.ctrl <= '0;
         outputs.data <= '0;
      end else begin
         state        <= stateNext;
         misalign     <= idle && misAl;
         outputs.ctrl <= wbCtrl;
         outputs.data <= wbData;
      end
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline. Consumes the EX/MEM bundle, drives the data-memory request/response port, formats load data, and writes the MEM/WB pipeline register through the write side of `memwb_if`. It also stalls the front of the pipeline while a memory transaction is outstanding.

## Interface
Parameters:
- `XLEN`, default 32: datapath width; only 32 is supported.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `inputs`  `exmem_if.rd`  bundle, read side:
  - `ctrl`: `RegWrite`, `ResultSrc[1:0]`, `MemWrite`.
  - `data`: `ALUResult`, `WriteData`, `PCPlus4`, `ImmExt`, `Rd[4:0]`, `funct3[2:0]`.
- `outputs`  `memwb_if.wr`  bundle, write side: registered `ctrl.{RegWrite,ResultSrc}` and `data.{ALUResult,load_data,PCPlus4,ImmExt,Rd}`.
- `dmem_req_valid`  out  1: request present.
- `dmem_req_ready`  in  1: memory accepts the request.
- `dmem_we`  out  1: 1 = store, 0 = load.
- `dmem_addr`  out  32: word-aligned address, `{ALUResult[31:2],2'b00}`.
- `dmem_wdata`  out  32: lane-replicated store data.
- `dmem_be`  out  4: byte enables.
- `dmem_rsp_valid`  in  1: load data valid.
- `dmem_rdata`  in  32: raw load word.
- `mem_stall`  out  1: hold IF/ID/EX and the EX/MEM register.
- `misalign`  out  1: one-cycle pulse on a misaligned access.

## Operation
- Op classes:
  - load = `ResultSrc==2'b01 && RegWrite`.
  - store = `MemWrite`.
  - Anything else is pass-through.
- FSM with two states, `IDLE` and `WAIT_RSP`. Reset state is `IDLE`.
- In `IDLE`:
  - Pass-through: MEM/WB loads the EX/MEM fields and `load_data` = 0. `mem_stall` = 0.
  - Store: `dmem_req_valid` = 1 and `mem_stall` = `!dmem_req_ready`. On the ready cycle, MEM/WB loads the store (RegWrite = 0); otherwise MEM/WB loads a bubble.
  - Load: `dmem_req_valid` = 1 and `mem_stall` = 1. On the ready cycle, go to `WAIT_RSP`. MEM/WB loads a bubble.
- In `WAIT_RSP`:
  - `dmem_req_valid` = 0.
  - `mem_stall` = `!dmem_rsp_valid`.
  - On `rsp_valid`: MEM/WB loads the load with `load_data` = formatted `dmem_rdata`, then go to `IDLE`.
  - Otherwise: MEM/WB loads a bubble.
- Bubble: `RegWrite` = 0, `ResultSrc` = 0, `Rd` = 0, all data fields 0.
- Request signals hold stable while `valid && !ready` (upstream is stalled). `dmem_req_valid` never drops before acceptance.
- Store lanes by `funct3`:
  - SB: `be` = `4'b0001 << a[1:0]`, `wdata` = byte ×4.
  - SH: `be` = `4'b0011 << {a[1],1'b0}`, `wdata` = half ×2.
  - SW: `be` = `4'hF`.
- Load format by `funct3`, lane chosen by `a[1:0]`:
  - LB (000) and LH (001): sign-extend.
  - LW (010): full word.
  - LBU (100) and LHU (101): zero-extend.
  - Other `funct3` values: treated as LW.
- Misaligned access (half with `a[0]`=1, or word with `a[1:0]`≠0):
  - No request is issued.
  - `misalign` pulses for one cycle.
  - MEM/WB loads a bubble.
  - `mem_stall` = 0.

## Timing
- Reset values: all MEM/WB fields 0, `dmem_req_valid` = 0, `dmem_we` = 0, `dmem_be` = 0, `mem_stall` = 0, `misalign` = 0. FSM = `IDLE`.
- Pass-through latency: 1 cycle, EX/MEM → MEM/WB.
- Store with ready already high: 1 cycle, no stall.
- Load minimum: 2 cycles (accept, then response). `rsp_valid` is ignored in `IDLE`, so a same-cycle response is not supported.
- Stall cycles:
  - Load: (cycles to ready − 1) + cycles in `WAIT_RSP` before `rsp_valid` + 1.
  - Store: cycles to ready − 1.
- `mem_stall` is combinational from state and the handshake inputs.
- Reset asserted mid-transaction: FSM returns to `IDLE` immediately and any in-flight response is discarded. The memory shares `rst_n`.
- Back-to-back memory ops: the next request is issued in the cycle after the previous one completes. There is no pipelining of requests (one outstanding request at most).

## Structure
- The shared pipeline package holds:
  - `mem_state_t` enum (`IDLE`, `WAIT_RSP`).
  - `funct3` constants (`F3_LB` … `F3_LHU`, `F3_SB`/`F3_SH`/`F3_SW`).
  - `RESULT_LOAD = 2'b01`.
- Sub-module `load_align`: combinational, inputs `rdata`, `addr[1:0]`, `funct3`; output extended `load_data`. Store-lane logic stays inline.

## Test plan
- ALU op (`ALUResult=0x1234`, `Rd=5`), no memory op → next cycle MEM/WB `ALUResult=0x1234`, `Rd=5`, `RegWrite=1`, `mem_stall=0`, `dmem_req_valid=0`.
- LB at `0x103`, `rdata=0x80FF_0000`, ready immediate, rsp 1 cycle later → `load_data=0xFFFF_FF80`. `mem_stall` high 1 cycle, low in the response cycle.
- SH `0xABCD` to `0x202`, ready low 3 cycles → `be=4'b1100`, `wdata=0xABCD_ABCD`, `addr=0x200`, `mem_stall` high 3 cycles, MEM/WB bubbles during the stall, MEM/WB takes the store with `RegWrite=0` on the ready cycle.
- LW at `0x006` → `misalign` pulses once, no request issued, MEM/WB bubble, no stall.
- LHU at `0x102` accepted, `rst_n` dropped while in `WAIT_RSP` → FSM `IDLE` and all outputs 0 immediately. A later `rsp_valid` is ignored.
- Back-to-back LW then SW, memory always ready → request cycles are consecutive after the load's response. The LW result is `rdata` unchanged.
